// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array blocks: operand width default
// and the operand streamer's FSM state encoding.
package systolic_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/operand_streamer_if.sv
// Operand handshake toward a MAC edge input: data/waiting/finished flow from
// the source (master), ready flows back from the MAC (slave).
interface operand_streamer_if #(
    parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_waiting;
    logic                  out_finished;
    logic                  out_ready;

    modport master (output out_data, output out_waiting, output out_finished, input out_ready);
    modport slave  (input out_data, input out_waiting, input out_finished, output out_ready);
endinterface

// File: rtl/operand_streamer.sv
// Holds one operand vector in a local buffer and replays it over the MAC
// operand handshake, one pass per dot product.
module operand_streamer
    import systolic_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int REP_W = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_W:0]       len,
    input  logic [REP_W-1:0]      reps,
    operand_streamer_if.master    out_if,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    stream_state_e         state_q, state_d;
    logic [ADDR_W:0]       idx_q, idx_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [REP_W-1:0]      pass_q, pass_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  waiting_q, waiting_d;
    logic                  finished_q, finished_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_W:0]       eff_len;
    logic [REP_W-1:0]      eff_reps;
    logic [ADDR_W:0]       idx_inc;
    logic                  xfer;
    logic                  last_elem;

    // Buffer is writable only while idle, so it is frozen during a stream.
    assign mem_we = wr_en && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign eff_len   = (len > DEPTH_L) ? DEPTH_L : len;
    assign eff_reps  = (reps == '0) ? REP_W'(1) : reps;
    assign idx_inc   = idx_q + 1'b1;
    assign xfer      = waiting_q && out_if.out_ready;
    assign last_elem = (idx_q == len_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pass_d     = pass_q;
        data_d     = data_q;
        waiting_d  = waiting_q;
        finished_d = finished_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (eff_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = STREAM;
                        idx_d      = '0;
                        len_d      = eff_len;
                        pass_d     = eff_reps;
                        data_d     = mem[0];
                        waiting_d  = 1'b1;
                        finished_d = (eff_len == (ADDR_W+1)'(1));
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (!last_elem) begin
                        idx_d      = idx_inc;
                        data_d     = mem[idx_inc[ADDR_W-1:0]];
                        finished_d = (idx_inc == len_q - 1'b1);
                    end else if (pass_q > REP_W'(1)) begin
                        // Wrap straight into the next pass with no bubble.
                        idx_d      = '0;
                        pass_d     = pass_q - 1'b1;
                        data_d     = mem[0];
                        finished_d = (len_q == (ADDR_W+1)'(1));
                    end else begin
                        state_d    = DONE;
                        idx_d      = '0;
                        pass_d     = '0;
                        waiting_d  = 1'b0;
                        finished_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            pass_q     <= '0;
            data_q     <= '0;
            waiting_q  <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pass_q     <= pass_d;
            data_q     <= data_d;
            waiting_q  <= waiting_d;
            finished_q <= finished_d;
        end
    end

    assign out_if.out_data     = data_q;
    assign out_if.out_waiting  = waiting_q;
    assign out_if.out_finished = finished_q;
    assign busy                = (state_q == STREAM);
    assign done                = (state_q == DONE);

endmodule

// File: tb/tb_operand_streamer.sv
// Directed and randomized checks of operand_streamer against a queue-based
// model of the expected beat sequence.
module tb_operand_streamer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [7:0]    reps = '0;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];

    typedef struct {
        logic [DW-1:0] data;
        logic          fin;
    } beat_t;

    beat_t exp_q[$];

    operand_streamer_if #(.DATA_WIDTH(DW)) sif ();

    operand_streamer #(.DEPTH(DEPTH), .REP_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .len     (len),
        .reps    (reps),
        .out_if  (sif.master),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after a posedge + #1.
    task automatic wr(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // mode: 0 ready always high, 1 fixed stall pattern, 2 random ready.
    task automatic run(input int l, input int r, input int mode, input bit inject);
        int el, er, cyc, beat;
        logic rdy, xfer;
        logic [6:0] pat;
        pat = 7'b1011001;   // read LSB first: 1,0,0,1,1,0,1
        el = (l > DEPTH) ? DEPTH : l;
        er = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int p = 0; p < er; p++)
            for (int i = 0; i < el; i++)
                exp_q.push_back('{data: model_mem[i], fin: (i == el - 1)});
        $display("stream len=%0d reps=%0d mode=%0d inject=%0d beats=%0d", l, r, mode, inject, exp_q.size());
        len   = 5'(l);
        reps  = 8'(r);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (el == 0) begin
            chk("len0_done", done, 1'b1);
            chk("len0_waiting", sif.out_waiting, 1'b0);
            chk("len0_busy", busy, 1'b0);
            @(posedge clk);
            #1;
            chk("len0_done_clear", done, 1'b0);
            return;
        end
        cyc = 0;
        beat = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            chk("busy", busy, 1'b1);
            chk("waiting", sif.out_waiting, 1'b1);
            chk("data", sif.out_data, exp_q[0].data);
            chk("finished", sif.out_finished, exp_q[0].fin);
            chk("no_done", done, 1'b0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 7];
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            sif.out_ready = rdy;
            if (inject && beat == 1) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_data = 32'd99;
                start   = 1'b1;
            end
            xfer = sif.out_waiting && rdy;
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            start = 1'b0;
            if (xfer) begin
                void'(exp_q.pop_front());
                beat++;
            end
            cyc++;
        end
        if (exp_q.size() > 0)
            chk("stream_timeout", 64'(exp_q.size()), 64'd0);
        chk("end_done", done, 1'b1);
        chk("end_busy", busy, 1'b0);
        chk("end_waiting", sif.out_waiting, 1'b0);
        chk("end_finished", sif.out_finished, 1'b0);
        // A start during the done cycle must be ignored.
        sif.out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_clear", done, 1'b0);
        chk("done_start_ignored", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_after_ignored_start", busy, 1'b0);
    endtask

    initial begin
        sif.out_ready = 1'b0;
        #3;
        chk("rst_waiting", sif.out_waiting, 1'b0);
        chk("rst_finished", sif.out_finished, 1'b0);
        chk("rst_data", sif.out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        wr(0, 32'd10);
        wr(1, 32'd20);
        wr(2, 32'd30);
        wr(3, 32'd40);

        run(4, 1, 0, 0);
        run(4, 1, 1, 0);
        run(3, 3, 0, 0);
        run(0, 1, 0, 0);
        run(2, 0, 0, 0);
        run(4, 1, 0, 1);

        // Asynchronous reset while beat 2 is stalled.
        $display("reset mid-stream");
        len = 5'd4;
        reps = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        chk("pre_rst_data", sif.out_data, 32'd20);
        #2 rst = 1'b0;
        #1;
        chk("arst_waiting", sif.out_waiting, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_finished", sif.out_finished, 1'b0);
        @(posedge clk);
        #1;
        chk("arst_no_done", done, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run(4, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++)
            wr(i, $urandom);
        run(16, 1, 2, 0);
        run(1, 3, 2, 0);
        run(20, 2, 2, 0);
        for (int k = 0; k < 5; k++)
            run($urandom_range(16, 1), $urandom_range(3, 1), 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
